// File: rtl/gpr_wr_arbiter_pkg.sv
// Shared constants for the GPR write-port arbiter family.
// Default sizes, the r0 encoding and the post-reset round-robin pointer.
package gpr_arb_pkg;

  localparam int NREQ_DEF = 3;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         RST_PTR  = NREQ_DEF - 1;

  // Pointer value that leaves requester 0 with top priority out of reset.
  function automatic int rst_ptr(input int nreq);
    return nreq - 1;
  endfunction

endpackage

// File: rtl/gpr_wr_arbiter_if.sv
// Writeback request bundle: per-requester valid/destination/data and the
// one-hot ready returned by the arbiter.
interface gpr_wr_if
  import gpr_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rw;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_rw,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rw,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/gpr_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of the eligible mask
// searched upward from (last + 1) mod N, wrapping around.
module rr_pick
  import gpr_arb_pkg::*;
#(
  parameter  int N  = NREQ_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int c;
    c     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(i_last) + k) % N;
      if (!o_any && i_mask[c]) begin
        o_any    = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/gpr_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// writeback requesters; registers the winning write and drops writes to r0.
module gpr_wr_arbiter
  import gpr_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int AW   = AW_DEF,
  parameter  int DW   = DW_DEF,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          hold,
  gpr_wr_if.slave       req,
  output logic          GPRWr,
  output logic [AW-1:0] rw,
  output logic [DW-1:0] busW,
  output logic [IW-1:0] last_gnt
);

  localparam logic [IW-1:0] RST_IDX = IW'(rst_ptr(NREQ));
  localparam logic [AW-1:0] ZERO_RW = AW'(REG_ZERO);

  logic [NREQ-1:0] w_eligible;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [AW-1:0]   w_selRw;
  logic [DW-1:0]   w_selData;

  logic            r_gprWr;
  logic [AW-1:0]   r_rw;
  logic [DW-1:0]   r_busW;
  logic [IW-1:0]   r_lastGnt;

  assign w_eligible    = req.req_valid & {NREQ{~hold}};
  assign req.req_ready = w_gnt;

  rr_pick #(.N(NREQ)) u_pick (
    .i_mask (w_eligible),
    .i_last (r_lastGnt),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // One-hot OR mux keeps the select path free of a decoded index.
  always_comb begin
    w_selRw   = '0;
    w_selData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_selRw   = w_selRw   | req.req_rw[i*AW +: AW];
        w_selData = w_selData | req.req_data[i*DW +: DW];
      end
    end
  end

  // An r0 write is still consumed and still moves the pointer; only the enable is dropped.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_gprWr   <= 1'b0;
      r_rw      <= '0;
      r_busW    <= '0;
      r_lastGnt <= RST_IDX;
    end else begin
      r_gprWr <= w_any && (w_selRw != ZERO_RW);
      if (w_any) begin
        r_rw      <= w_selRw;
        r_busW    <= w_selData;
        r_lastGnt <= w_idx;
      end
    end
  end

  assign GPRWr    = r_gprWr;
  assign rw       = r_rw;
  assign busW     = r_busW;
  assign last_gnt = r_lastGnt;

endmodule
